// File: rtl/adc_resp_pkg.sv
// Shared types for the ADC serial responder: FSM states and control-byte field positions.
package adc_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CTRL   = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_STROBE = 3'd3,
      ST_SHIFT  = 3'd4
   } state_t;

   localparam int CTRL_BITS = 8;
   localparam int START_BIT = 7;
   localparam int SEL_HI    = 6;
   localparam int SEL_LO    = 4;
   localparam int UNI_BIT   = 3;
   localparam int SGL_BIT   = 2;
   localparam int PD_HI     = 1;
   localparam int PD_LO     = 0;

endpackage

// File: rtl/adc_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, with one-clock rise/fall pulses
// derived from the synchronized level.
module adc_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Device-side model of the serial ADC link: takes a control byte, fetches one sample,
// returns it MSB-first after an SSTRB marker. Define ADC_RESP_TESTPAT_EN for a counting test pattern.
module adc_serial_responder
   import adc_resp_pkg::*;
#(
   parameter int DATA_W      = 12,
   parameter int PAD_BITS    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              ad_sclk,
   input  logic              ad_din,
   output logic              ad_dout,
   output logic              ad_sstrb,
   output logic [2:0]        smp_chan,
   input  logic [DATA_W-1:0] smp_data,
   input  logic              smp_valid,
   output logic              smp_ready,
   output logic [7:0]        underrun_cnt,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   localparam int FRAME_BITS = DATA_W + PAD_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_CTRL_LAST = CNT_W'(CTRL_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_BITS);

   // Handshake: smp_ready is a single-cycle request; the sample is taken in that
   // same cycle if smp_valid is high, otherwise the previous sample is replayed.

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic din_lvl, din_rise_unused, din_fall_unused;

   adc_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .d     (ad_sclk),
      .level (sclk_lvl_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   adc_edge_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .d     (ad_din),
      .level (din_lvl),
      .rise  (din_rise_unused),
      .fall  (din_fall_unused)
   );

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CTRL_BITS-1:0]   ctrl;
   logic [DATA_W-1:0]      shreg;
   logic                   ctrl_unused;

`ifdef ADC_RESP_TESTPAT_EN
   logic [DATA_W-4:0]      pat_cnt;
   logic                   smp_unused;
   assign smp_unused = ^{smp_data, smp_valid};
`else
   logic [DATA_W-1:0]      last;
`endif

   assign ctrl_unused = ^{ctrl[START_BIT], ctrl[UNI_BIT], ctrl[SGL_BIT], ctrl[PD_HI:PD_LO]};

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) state_q <= ST_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (sclk_rise && din_lvl) state_d = ST_CTRL;
         ST_CTRL:   if (sclk_rise && bit_cnt == CNT_CTRL_LAST) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = ST_STROBE;
         ST_STROBE: if (sclk_fall && ad_sstrb) state_d = ST_SHIFT;
         ST_SHIFT:  if (sclk_fall && bit_cnt == CNT_FRAME) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         bit_cnt      <= '0;
         ctrl         <= '0;
         shreg        <= '0;
         ad_dout      <= 1'b0;
         ad_sstrb     <= 1'b0;
         underrun_cnt <= 8'd0;
`ifdef ADC_RESP_TESTPAT_EN
         pat_cnt      <= '0;
`else
         last         <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sclk_rise && din_lvl) begin
                  ctrl    <= CTRL_BITS'(1);
                  bit_cnt <= CNT_W'(1);
               end
            end
            ST_CTRL: begin
               if (sclk_rise) begin
                  ctrl    <= {ctrl[CTRL_BITS-2:0], din_lvl};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
`ifdef ADC_RESP_TESTPAT_EN
               shreg   <= {ctrl[SEL_HI:SEL_LO], pat_cnt};
               pat_cnt <= pat_cnt + 1'b1;
`else
               if (smp_valid) begin
                  shreg <= smp_data;
                  last  <= smp_data;
               end else begin
                  shreg <= last;
                  if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
               end
`endif
            end
            ST_STROBE: begin
               // First fall raises the strobe, the second one replaces it with the MSB.
               if (sclk_fall) begin
                  if (!ad_sstrb) begin
                     ad_sstrb <= 1'b1;
                  end else begin
                     ad_sstrb <= 1'b0;
                     ad_dout  <= shreg[DATA_W-1];
                     shreg    <= {shreg[DATA_W-2:0], 1'b0};
                     bit_cnt  <= CNT_W'(1);
                  end
               end
            end
            ST_SHIFT: begin
               // Zeros shifted into shreg provide the padding bits.
               if (sclk_fall) begin
                  if (bit_cnt == CNT_FRAME) begin
                     ad_dout <= 1'b0;
                  end else begin
                     ad_dout <= shreg[DATA_W-1];
                     shreg   <= {shreg[DATA_W-2:0], 1'b0};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADC_RESP_TESTPAT_EN
   assign smp_ready = 1'b0;
`else
   assign smp_ready = (state_q == ST_SAMPLE);
`endif
   assign smp_chan  = ctrl[SEL_HI:SEL_LO];
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Scoreboard bench for adc_serial_responder: bench-driven SCLK frames, a frame-level model
// of the returned words, and independent monitors for DOUT/SSTRB and the sample request.
module tb_adc_serial_responder;

   localparam int DATA_W     = 12;
   localparam int PAD_BITS   = 4;
   localparam int FRAME_BITS = DATA_W + PAD_BITS;
   localparam int HALF       = 3;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic              ad_sclk = 1'b0;
   logic              ad_din = 1'b0;
   logic              ad_dout, ad_sstrb, smp_ready, busy;
   logic [2:0]        smp_chan, state_dbg;
   logic [DATA_W-1:0] smp_data = '0;
   logic              smp_valid = 1'b0;
   logic [7:0]        underrun_cnt;

   adc_serial_responder #(.DATA_W(DATA_W), .PAD_BITS(PAD_BITS), .SYNC_STAGES(2)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .ad_sclk       (ad_sclk),
      .ad_din        (ad_din),
      .ad_dout       (ad_dout),
      .ad_sstrb      (ad_sstrb),
      .smp_chan      (smp_chan),
      .smp_data      (smp_data),
      .smp_valid     (smp_valid),
      .smp_ready     (smp_ready),
      .underrun_cnt  (underrun_cnt),
      .busy          (busy),
      .state_dbg     (state_dbg)
   );

   // clock / reset
   always #5 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;
   logic [FRAME_BITS-1:0] exp_q[$];
   logic [2:0]            chan_q[$];
   logic                  mon_abort = 1'b0;

   // frame-level reference model
   logic [DATA_W-1:0] m_last = '0;
   int                m_und = 0;
   int                m_pat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // driver tasks: each SCLK period is low HALF clocks then high HALF clocks
   task automatic sclk_period(input logic din_v);
      ad_din = din_v;
      repeat (HALF) @(negedge clk_clk);
      ad_sclk = 1'b1;
      repeat (HALF) @(negedge clk_clk);
      ad_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sclk_period(b[i]);
   endtask

   task automatic run_frame(input logic [7:0] ctrl_b, input int lead_bytes, input int tail);
      repeat (lead_bytes) send_byte(8'h00);
      send_byte(ctrl_b);
      repeat (tail) sclk_period(1'b0);
   endtask

   task automatic model_frame(input logic [7:0] ctrl_b, input logic [DATA_W-1:0] data,
                              input logic valid, output logic [DATA_W-1:0] resp);
      logic [2:0] chan;
      chan = ctrl_b[6:4];
`ifdef ADC_RESP_TESTPAT_EN
      resp  = {chan, m_pat[8:0]};
      m_pat = (m_pat + 1) % 512;
`else
      if (valid) begin
         resp   = data;
         m_last = data;
      end else begin
         resp = m_last;
         if (m_und < 255) m_und++;
      end
      chan_q.push_back(chan);
`endif
   endtask

   task automatic issue_frame(input logic [7:0] ctrl_b, input int lead_bytes,
                              input logic [DATA_W-1:0] data, input logic valid);
      logic [DATA_W-1:0] resp;
      smp_data  = data;
      smp_valid = valid;
      model_frame(ctrl_b, data, valid, resp);
      exp_q.push_back({resp, {PAD_BITS{1'b0}}});
      run_frame(ctrl_b, lead_bytes, 18);
      check("busy_after_frame", busy, 0);
      check("dout_after_frame", ad_dout, 0);
   endtask

   // monitor: serial output, sampled on bench SCLK rising edges
   int                    bit_idx = -1;
   int                    strb_extra = 0;
   logic [FRAME_BITS-1:0] got, want;

   always @(posedge ad_sclk) begin
      if (mon_abort) begin
         bit_idx   = -1;
         mon_abort = 1'b0;
      end
      if (bit_idx < 0) begin
         if (ad_sstrb) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe actual=1 required=0");
            end else begin
               want       = exp_q.pop_front();
               got        = '0;
               strb_extra = 0;
               bit_idx    = 0;
            end
         end
      end else begin
         if (ad_sstrb) strb_extra++;
         got[FRAME_BITS-1-bit_idx] = ad_dout;
         bit_idx++;
         if (bit_idx == FRAME_BITS) begin
            check("frame_data", got, want);
            check("sstrb_width", strb_extra, 0);
            bit_idx = -1;
         end
      end
   end

   // monitor: sample request pulse and channel
   logic ready_prev = 1'b0;
   always @(negedge clk_clk) begin
      if (smp_ready) begin
         if (chan_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual=1 required=0");
         end else begin
            check("smp_chan", smp_chan, chan_q.pop_front());
         end
         check("ready_pulse_width", ready_prev, 0);
      end
      ready_prev = smp_ready;
   end

   initial begin
      logic [DATA_W-1:0] resp;
      repeat (5) @(negedge clk_clk);
      check("rst_dout", ad_dout, 0);
      check("rst_sstrb", ad_sstrb, 0);
      check("rst_ready", smp_ready, 0);
      check("rst_chan", smp_chan, 0);
      check("rst_busy", busy, 0);
      check("rst_underrun", underrun_cnt, 0);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);

      // basic frame, then the same frame after a leading zero byte
      issue_frame(8'hBF, 0, 12'hABC, 1'b1);
      issue_frame(8'hBF, 1, 12'hABC, 1'b1);

      // two underruns replay the last good sample
      issue_frame(8'hA3, 0, 12'h123, 1'b1);
      issue_frame(8'hC7, 0, 12'(($urandom)), 1'b0);
      issue_frame(8'hF1, 0, 12'(($urandom)), 1'b0);
      check("underrun_two", underrun_cnt, m_und);

      // channel 5 pattern frames (meaningful under the test-pattern build)
      for (int i = 0; i < 3; i++) issue_frame(8'hD0, 0, 12'($urandom), 1'b1);

      for (int i = 0; i < 8; i++)
         issue_frame({1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))},
                     $urandom_range(0, 1), 12'($urandom), 1'($urandom_range(0, 1)));
      check("underrun_random", underrun_cnt, m_und);

      // saturation
      for (int i = 0; i < 256; i++)
         issue_frame({1'b1, 3'($urandom_range(0, 7)), 4'h0}, 0, 12'($urandom), 1'b0);
      check("underrun_sat", underrun_cnt, m_und);

      // reset while bit 5 of the shift phase is on DOUT
      smp_data  = 12'hFFF;
      smp_valid = 1'b1;
      model_frame(8'hBF, 12'hFFF, 1'b1, resp);
      exp_q.push_back({resp, {PAD_BITS{1'b0}}});
      run_frame(8'hBF, 0, 5);
      repeat (3) @(negedge clk_clk);
      check("mid_frame_busy", busy, 1);
`ifndef ADC_RESP_TESTPAT_EN
      check("mid_frame_dout", ad_dout, 1);
`endif
      reset_reset_n = 1'b0;
      @(posedge clk_clk);
      #1;
      check("abort_dout", ad_dout, 0);
      check("abort_sstrb", ad_sstrb, 0);
      check("abort_busy", busy, 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      mon_abort     = 1'b1;
      m_last        = '0;
      m_und         = 0;
      m_pat         = 0;
      check("underrun_after_reset", underrun_cnt, 0);
      repeat (2) @(negedge clk_clk);
      issue_frame(8'h8F, 0, 12'($urandom), 1'b1);
      issue_frame(8'hD5, 0, 12'($urandom), 1'b0);
      check("underrun_final", underrun_cnt, m_und);

      repeat (20) @(negedge clk_clk);
      check("frames_left", exp_q.size(), 0);
      check("requests_left", chan_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
